// File: rtl/ss_scan_reader.sv
// Reader for a multiplexed seven-segment display: it watches the an/a_to_g lines and recovers
// the BCD digit shown at each position, flags illegal patterns and reports completed frames.
module ss_scan_reader #(
  parameter int unsigned NDIG       = 4,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NDIG-1:0]   an,
  input  logic [6:0]        a_to_g,
  output logic [4*NDIG-1:0] digits,
  output logic [NDIG-1:0]   digit_err,
  output logic              upd,
  output logic [2:0]        upd_idx,
  output logic              frame_valid
);

  localparam int unsigned TW     = NDIG + 7;
  localparam logic [7:0]  CntMax = 8'(STABLE_CYC);

  typedef enum logic {StTrack, StHold} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     sync1_q, sync2_q, prev_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [NDIG-1:0]   seen_q, seen_d;
  logic [4*NDIG-1:0] digits_q, digits_d;
  logic [NDIG-1:0]   err_q, err_d;
  logic              upd_q, fv_q;
  logic [2:0]        idx_q;

  logic              changed, one_hot, capture, frame_done, dec_ok;
  logic [NDIG-1:0]   an_low, seen_set;
  logic [2:0]        sel_idx;
  logic [3:0]        dec_val;

  // Reset to all ones: blank segments, no anode selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {an, a_to_g};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign changed = (sync2_q != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // The counter measures how long prev_q has held, so decode from prev_q.
  assign an_low  = ~prev_q[TW-1:7];
  assign one_hot = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (an_low[i]) sel_idx = 3'(i);
    end
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    case (prev_q[6:0])
      7'b0000001: dec_val = 4'd0;
      7'b1001111: dec_val = 4'd1;
      7'b0010010: dec_val = 4'd2;
      7'b0000110: dec_val = 4'd3;
      7'b1001100: dec_val = 4'd4;
      7'b0100100: dec_val = 4'd5;
      7'b0100000: dec_val = 4'd6;
      7'b0001111: dec_val = 4'd7;
      7'b0000000: dec_val = 4'd8;
      7'b0000100: dec_val = 4'd9;
      default:    dec_ok  = 1'b0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StTrack;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. A tuple that changes on the capture cycle keeps tracking so the new
  // window is not lost.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StTrack: if (capture && !changed) state_d = StHold;
      StHold:  if (changed) state_d = StTrack;
      default: state_d = StTrack;
    endcase
  end

  // FSM: outputs
  always_comb begin
    capture = (state_q == StTrack) && (cnt_q == CntMax) && one_hot;
  end

  assign seen_set   = seen_q | an_low;
  assign frame_done = capture && (&seen_set);

  always_comb begin
    seen_d   = seen_q;
    digits_d = digits_q;
    err_d    = err_q;
    if (capture) begin
      seen_d = frame_done ? '0 : seen_set;
      for (int unsigned i = 0; i < NDIG; i++) begin
        if (an_low[i]) begin
          if (dec_ok) begin
            digits_d[4*i +: 4] = dec_val;
            err_d[i]           = 1'b0;
          end else begin
            err_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q   <= '0;
      digits_q <= '0;
      err_q    <= '0;
      upd_q    <= 1'b0;
      idx_q    <= '0;
      fv_q     <= 1'b0;
    end else begin
      seen_q   <= seen_d;
      digits_q <= digits_d;
      err_q    <= err_d;
      upd_q    <= capture;
      idx_q    <= capture ? sel_idx : 3'd0;
      fv_q     <= frame_done;
    end
  end

  assign digits      = digits_q;
  assign digit_err   = err_q;
  assign upd         = upd_q;
  assign upd_idx     = idx_q;
  assign frame_valid = fv_q;

endmodule

// File: tb/tb_ss_scan_reader.sv
// Bench for ss_scan_reader: a pin-level run-length model predicts every capture, and each
// scenario task compares the DUT against it cycle by cycle plus targeted constant checks.
module tb_ss_scan_reader;

  localparam int N = 4;
  localparam int S = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   an = '1;
  logic [6:0]     a_to_g = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_err;
  logic           upd;
  logic [2:0]     upd_idx;
  logic           frame_valid;

  ss_scan_reader #(.NDIG(N), .STABLE_CYC(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .a_to_g      (a_to_g),
    .digits      (digits),
    .digit_err   (digit_err),
    .upd         (upd),
    .upd_idx     (upd_idx),
    .frame_valid (frame_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model: a capture fires 3 edges after a pin tuple has been sampled S times in a
  // row with exactly one anode low.
  typedef struct {int due; int idx; logic [6:0] seg;} cap_t;
  cap_t           pend [$];
  logic [N+6:0]   run_val;
  int             run_len;
  int             ecnt;
  logic [4*N-1:0] m_digits;
  logic [N-1:0]   m_err, m_seen;
  logic           m_upd, m_fv;
  logic [2:0]     m_idx;

  logic [5*N+4:0] obs, expv;
  assign obs  = {upd, upd_idx, frame_valid, digit_err, digits};
  assign expv = {m_upd, m_idx, m_fv, m_err, m_digits};

  task automatic model_reset();
    pend.delete();
    run_val = '1;
    run_len = 0;
    ecnt = -1;
    m_digits = '0; m_err = '0; m_seen = '0;
    m_upd = 1'b0; m_fv = 1'b0; m_idx = '0;
  endtask

  task automatic model_step();
    logic [N+6:0] p;
    cap_t c;
    int zeros, idx, val;
    p = {an, a_to_g};
    if (p == run_val) run_len++;
    else begin
      run_val = p;
      run_len = 1;
    end
    ecnt++;
    m_upd = 1'b0; m_idx = '0; m_fv = 1'b0;
    if (pend.size() > 0 && pend[0].due == ecnt) begin
      c = pend.pop_front();
      val = -1;
      for (int j = 0; j < 10; j++) if (seg_tab[j] == c.seg) val = j;
      if (val >= 0) begin
        m_digits[4*c.idx +: 4] = 4'(val);
        m_err[c.idx] = 1'b0;
      end else begin
        m_err[c.idx] = 1'b1;
      end
      m_upd = 1'b1;
      m_idx = 3'(c.idx);
      m_seen[c.idx] = 1'b1;
      if (&m_seen) begin
        m_fv = 1'b1;
        m_seen = '0;
      end
    end
    zeros = 0; idx = 0;
    for (int i = 0; i < N; i++) if (!run_val[7+i]) begin zeros++; idx = i; end
    if (run_len == S && zeros == 1) begin
      c.due = ecnt + 3; c.idx = idx; c.seg = run_val[6:0];
      pend.push_back(c);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; an = '1; a_to_g = '1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== '0) $display("FAIL reset_state: got %h expected 0", obs);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1; an = 4'b1110; a_to_g = 7'b0010010;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      checks++;
      if (upd !== (k == 6)) $display("FAIL reset_latency edge %0d: upd=%b expected %b", k, upd, k == 6);
      else passes++;
      checks++;
      if (obs !== expv) $display("FAIL reset_model edge %0d: got %h expected %h", k, obs, expv);
      else passes++;
    end
    checks++;
    if (digits[3:0] !== 4'd2 || digit_err !== '0)
      $display("FAIL reset_capture: digit0=%0d err=%b expected 2 and 0", digits[3:0], digit_err);
    else passes++;
  endtask

  task automatic test_scan();
    int fv_cnt = 0;
    for (int sc = 0; sc < 2; sc++) begin
      for (int pos = 0; pos < N; pos++) begin
        an = ~(4'b0001 << pos);
        a_to_g = (pos == 0) ? seg_tab[1] : (pos == 1) ? seg_tab[2] : (pos == 2) ? seg_tab[3] : seg_tab[9];
        repeat (8) begin
          @(posedge clk); #1;
          fv_cnt += int'(frame_valid);
          checks++;
          if (obs !== expv) $display("FAIL scan pos %0d: got %h expected %h", pos, obs, expv);
          else passes++;
        end
      end
    end
    checks++;
    if (fv_cnt !== 2) $display("FAIL scan_frames: got %0d expected 2", fv_cnt);
    else passes++;
    checks++;
    if (digits !== 16'h9321) $display("FAIL scan_digits: got %h expected 9321", digits);
    else passes++;
  endtask

  task automatic test_illegal();
    logic [6:0] segs [3];
    segs = '{7'b0100100, 7'b1111110, 7'b0000110};
    an = 4'b1101;
    for (int ph = 0; ph < 3; ph++) begin
      a_to_g = segs[ph];
      repeat (8) begin
        @(posedge clk); #1;
        checks++;
        if (obs !== expv) $display("FAIL illegal phase %0d: got %h expected %h", ph, obs, expv);
        else passes++;
      end
      if (ph == 1) begin
        checks++;
        if (digit_err[1] !== 1'b1 || digits[7:4] !== 4'd5)
          $display("FAIL illegal_keep: err=%b digit=%0d expected 1 and 5", digit_err[1], digits[7:4]);
        else passes++;
      end
    end
    checks++;
    if (digit_err[1] !== 1'b0 || digits[7:4] !== 4'd3)
      $display("FAIL illegal_clear: err=%b digit=%0d expected 0 and 3", digit_err[1], digits[7:4]);
    else passes++;
  endtask

  task automatic test_glitch();
    int upd_cnt = 0;
    int lens [3];
    logic [6:0] segs [3];
    lens = '{8, 3, 10};
    segs = '{7'b0000000, 7'b1001111, 7'b0000000};
    an = 4'b1011;
    for (int ph = 0; ph < 3; ph++) begin
      a_to_g = segs[ph];
      repeat (lens[ph]) begin
        @(posedge clk); #1;
        upd_cnt += int'(upd);
        checks++;
        if (obs !== expv) $display("FAIL glitch phase %0d: got %h expected %h", ph, obs, expv);
        else passes++;
      end
    end
    checks++;
    if (upd_cnt !== 2) $display("FAIL glitch_count: got %0d expected 2", upd_cnt);
    else passes++;
    checks++;
    if (digits[11:8] !== 4'd8) $display("FAIL glitch_digit: got %0d expected 8", digits[11:8]);
    else passes++;
  endtask

  task automatic test_no_anode();
    int upd_cnt = 0;
    logic [3:0] ans [2];
    ans = '{4'b1100, 4'b1111};
    a_to_g = 7'b0000001;
    for (int ph = 0; ph < 2; ph++) begin
      an = ans[ph];
      repeat (20) begin
        @(posedge clk); #1;
        // The first few cycles may still show the previous tuple's capture.
        if (ph == 1) upd_cnt += int'(upd);
        checks++;
        if (obs !== expv) $display("FAIL no_anode an=%b: got %h expected %h", an, obs, expv);
        else passes++;
      end
    end
    checks++;
    if (upd_cnt !== 0) $display("FAIL no_anode_count: got %0d expected 0", upd_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid();
    an = 4'b0111; a_to_g = 7'b0001111;
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (upd !== 1'b0) $display("FAIL reset_mid_pre edge %0d: upd=%b expected 0", k, upd);
      else passes++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== '0) $display("FAIL reset_mid_clear: got %h expected 0", obs);
    else passes++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checks++;
      if (upd !== (k == S + 2)) $display("FAIL reset_mid_latency edge %0d: upd=%b expected %b", k, upd, k == S + 2);
      else passes++;
      checks++;
      if (obs !== expv) $display("FAIL reset_mid_model edge %0d: got %h expected %h", k, obs, expv);
      else passes++;
    end
  endtask

  task automatic test_random();
    int pos;
    for (int n = 0; n < 80; n++) begin
      pos = $urandom_range(0, N - 1);
      an = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ~(4'b0001 << pos);
      a_to_g = ($urandom_range(0, 4) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 9)];
      repeat ($urandom_range(1, 9)) begin
        @(posedge clk); #1;
        checks++;
        if (obs !== expv) $display("FAIL random seg %0d: got %h expected %h", n, obs, expv);
        else passes++;
      end
    end
    repeat (10) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== expv) $display("FAIL random_tail: got %h expected %h", obs, expv);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_illegal();
    test_glitch();
    test_no_anode();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ss_scan_reader.md
Name: ss_scan_reader

Overview:
- Reader side of the team's multiplexed seven-segment display interface.
- Monitors the anode-enable and a_to_g segment lines that a display driver produces.
- Recovers the BCD digit shown on each position, flags illegal patterns and signals when a full frame has been captured.
- Sits beside the display driver for self-check, or on a board monitoring an external display.

Parameters:
- NDIG, 4: number of multiplexed digit positions (2..8).
- STABLE_CYC, 4: consecutive synchronised cycles a tuple {an, a_to_g} must hold before capture (2..255).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- an  input  NDIG  digit enables, active-low; an[i]=0 selects position i.
- a_to_g  input  7  segments; bit6=a ... bit0=g; segment lit when bit is 0.
- digits  output  4*NDIG  captured BCD values; digits[4i+3:4i] is position i.
- digit_err  output  NDIG  1 = last capture on position i was an illegal pattern.
- upd  output  1  one-cycle strobe per capture.
- upd_idx  output  3  position captured on the upd cycle; 0 when upd=0.
- frame_valid  output  1  one-cycle strobe when every position has been captured since the previous strobe.

Behaviour:
- Reset (async assert, sync release):
  - digits=0, digit_err=0, upd=0, upd_idx=0, frame_valid=0.
  - Seen-mask=0, stability counter=0, FSM=S_TRACK.
  - Synchroniser flops = all ones (blank, no anode).
- Input path:
  - an and a_to_g pass through a 2-flop synchroniser.
  - Third register holds the previous synced tuple for comparison.
- Stability counter (8-bit):
  - Synced tuple differs from previous: counter loads 1.
  - Otherwise: counter increments, saturating at STABLE_CYC.
- FSM S_TRACK:
  - When the counter equals STABLE_CYC and synced an is one-hot-low, capture and go to S_HOLD.
  - Zero anodes low or more than one low: no capture, remain in S_TRACK.
- FSM S_HOLD:
  - No further capture.
  - Return to S_TRACK on the first cycle the synced tuple changes; the counter reloads 1 in that cycle.
  - Result: exactly one capture per stable window.
- Capture registers upd=1 and upd_idx=i for one cycle and updates position i.
- Decode table (a_to_g -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4.
  - 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9.
  - Match: digits[i] loads the value and digit_err[i] clears.
  - Any other pattern: digits[i] keeps its old value and digit_err[i] sets.
- Latency:
  - A tuple first present at the pins for clock edge 0 and held produces upd asserted after edge STABLE_CYC+2.
  - digits and digit_err update on the same edge as upd.
- Frame tracking:
  - Seen-mask bit i sets on any capture of position i, whether legal or illegal.
  - If the capture completes the mask (all NDIG ones), frame_valid pulses in the same cycle as that upd and the mask clears to 0.
  - Re-capturing an already-seen position does not pulse frame_valid.
- Glitches: tuple changes shorter than STABLE_CYC synced cycles never capture; the counter restarts on each change.
- Reset mid-capture: all state clears immediately and no strobe is emitted; the next capture needs a full fresh stable window.

Test Plan:
- Reset with an=4'b1110, a_to_g=7'b0010010 held from first edge after release, STABLE_CYC=4 -> upd=1 and upd_idx=0 after edge 6; digits[3:0]=2, digit_err=0; upd low on all later cycles while held.
- Scan positions 0..3 showing 1,2,3,9 with 8 cycles each -> four upd pulses, idx 0,1,2,3; digits=16'h9321; frame_valid=1 exactly with the idx=3 upd; second scan pulses frame_valid again.
- Position 1 shows 7'b1111110 (illegal), then 7'b0000110 (legal 3), previous value 5 -> digit_err[1]=1 with digits[7:4]=5; then digit_err[1]=0 with digits[7:4]=3; illegal capture still sets the seen bit.
- Glitch: position 2 shows 8 stably, then a_to_g toggles to 7'b1001111 for 3 cycles and back -> only the first 8 captured; no capture of 1; one further capture of 8 once stable for 4 cycles.
- an=4'b1100 or 4'b1111 held for 20 cycles -> no upd, digits unchanged.
- Assert rst_n low on the cycle the counter reaches STABLE_CYC-1 -> no upd; all outputs 0; after release the same tuple captures only after a full STABLE_CYC+2 edges.
